sprite_blitter: RTL and testbench

//  Parametrised, positionable sprite renderer for the chess display. Replaces

---
 rtl/sprite_blitter.sv | 99 +++++++++
 tb/tb_sprite_blitter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Positionable palette-indexed sprite renderer with power-of-2 scale, h-flip,
// transparency and frame-counted blink. Fixed 3-cycle latency from DrawX/DrawY.
module sprite_blitter #(
    parameter int SPRITE_W   = 60,
    parameter int SPRITE_H   = 60,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 0,
    parameter int BLINK_LOG2 = 4,
    parameter int V_ACTIVE   = 480,
    localparam int ADDR_W    = $clog2(SPRITE_W*SPRITE_H)
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [1:0]        scale,
    input  logic              flip,
    input  logic              blink_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_hit
);

    logic [9:0]          pos_x_l, pos_y_l;
    logic [1:0]          scale_l;
    logic                flip_l, blink_en_l;
    logic [BLINK_LOG2:0] frame_cnt;
    logic [2:1]          vld_pipe;

    logic                latch_now;
    logic signed [10:0]  rx, ry;
    logic [13:0]         box_w, box_h;
    logic                in_box;
    logic [9:0]          col_raw, col, row;
    logic [ADDR_W-1:0]   addr_next;

    assign latch_now = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

    // Shadow registers only move during vertical blank, so a frame never tears.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            pos_x_l    <= '0;
            pos_y_l    <= '0;
            scale_l    <= '0;
            flip_l     <= 1'b0;
            blink_en_l <= 1'b0;
            frame_cnt  <= '0;
        end else if (latch_now) begin
            pos_x_l    <= pos_x;
            pos_y_l    <= pos_y;
            scale_l    <= scale;
            flip_l     <= flip;
            blink_en_l <= blink_en;
            frame_cnt  <= frame_cnt + 1'b1;
        end
    end

    // 11-bit signed offsets: a sign bit means left/above the sprite, never a wrap.
    always_comb begin
        rx      = $signed({1'b0, DrawX}) - $signed({1'b0, pos_x_l});
        ry      = $signed({1'b0, DrawY}) - $signed({1'b0, pos_y_l});
        box_w   = 14'(SPRITE_W) << scale_l;
        box_h   = 14'(SPRITE_H) << scale_l;
        in_box  = blank && !rx[10] && !ry[10]
                  && (14'(rx[9:0]) < box_w) && (14'(ry[9:0]) < box_h);
        col_raw = rx[9:0] >> scale_l;
        row     = ry[9:0] >> scale_l;
        col     = flip_l ? (10'(SPRITE_W - 1) - col_raw) : col_raw;
        addr_next = ADDR_W'(row) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_addr <= '0;
            vld_pipe <= '0;
        end else begin
            if (in_box)
                rom_addr <= addr_next;
            vld_pipe[1] <= in_box & ~(blink_en_l & frame_cnt[BLINK_LOG2]);
            vld_pipe[2] <= vld_pipe[1];
        end
    end

    // rom_q lines up with vld_pipe[2] because the external ROM adds one register.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            pix_idx <= '0;
            pix_hit <= 1'b0;
        end else begin
            pix_idx <= vld_pipe[2] ? rom_q : '0;
            pix_hit <= vld_pipe[2] && (rom_q != IDX_W'(TRANSP_IDX));
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: directed pixels push expected rom_addr
// (+1) and pix_idx/pix_hit (+3); a negedge monitor pops and compares.
module tb_sprite_blitter;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        blank, flip, blink_en;
    logic [1:0]  scale;
    logic [11:0] rom_addr;
    logic [3:0]  rom_q, pix_idx;
    logic        pix_hit;

    sprite_blitter dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .scale(scale),
        .flip(flip), .blink_en(blink_en), .rom_addr(rom_addr),
        .rom_q(rom_q), .pix_idx(pix_idx), .pix_hit(pix_hit)
    );

    always #5 vga_clk = ~vga_clk;

    // Registered external ROM: texel value = low nibble of address + 5 (mod 16).
    always @(posedge vga_clk) rom_q <= rom_addr[3:0] + 4'd5;

    typedef struct {
        int          due;
        logic [11:0] addr;
        logic [3:0]  idx;
        logic        hit;
        string       nm;
    } exp_t;

    exp_t aq[$];
    exp_t pq[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge vga_clk) begin
        exp_t e;
        if (aq.size() > 0 && aq[0].due <= cyc) begin
            e = aq.pop_front();
            check({e.nm, " due"}, cyc, e.due);
            check({e.nm, " rom_addr"}, int'(rom_addr), int'(e.addr));
        end
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            check({e.nm, " due"}, cyc, e.due);
            check({e.nm, " pix_idx"}, int'(pix_idx), int'(e.idx));
            check({e.nm, " pix_hit"}, int'(pix_hit), int'(e.hit));
        end
    end

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic bl,
                         input logic chk_a, input logic [11:0] ea,
                         input logic [3:0] ei, input logic eh, input string nm);
        exp_t e;
        @(negedge vga_clk);
        DrawX = x; DrawY = y; blank = bl;
        e.nm = nm; e.addr = ea; e.idx = ei; e.hit = eh;
        if (chk_a) begin
            e.due = cyc + 1;
            aq.push_back(e);
        end
        e.due = cyc + 3;
        pq.push_back(e);
    endtask

    task automatic latch(input logic [9:0] px, input logic [9:0] py,
                         input logic [1:0] sc, input logic f, input logic b);
        @(negedge vga_clk);
        pos_x = px; pos_y = py; scale = sc; flip = f; blink_en = b;
        drive(10'd0, 10'd480, 1'b0, 1'b0, 12'd0, 4'd0, 1'b0, "latch");
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (aq.size() + pq.size()) > 0; i++)
            @(negedge vga_clk);
        #1;
        check("drain", aq.size() + pq.size(), 0);
    endtask

    initial begin
        reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
        pos_x = '0; pos_y = '0; scale = '0; flip = 1'b0; blink_en = 1'b0;
        repeat (3) @(negedge vga_clk);
        check("reset rom_addr", int'(rom_addr), 0);
        check("reset pix_idx", int'(pix_idx), 0);
        check("reset pix_hit", int'(pix_hit), 0);
        reset = 1'b0;

        // scale 1x at (100,50)
        latch(10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
        drive(10'd100, 10'd50,  1'b1, 1'b1, 12'd0,    4'd5,  1'b1, "1x origin");
        drive(10'd101, 10'd50,  1'b1, 1'b1, 12'd1,    4'd6,  1'b1, "1x col1");
        drive(10'd159, 10'd109, 1'b1, 1'b1, 12'd3599, 4'd4,  1'b1, "1x corner");
        drive(10'd160, 10'd50,  1'b1, 1'b1, 12'd3599, 4'd0,  1'b0, "1x right edge");
        drive(10'd99,  10'd50,  1'b1, 1'b1, 12'd3599, 4'd0,  1'b0, "1x left edge");
        drive(10'd111, 10'd50,  1'b1, 1'b1, 12'd11,   4'd0,  1'b0, "transparent");
        drive(10'd105, 10'd51,  1'b0, 1'b1, 12'd11,   4'd0,  1'b0, "blank in box");

        // scale 2x: 120x120 box
        latch(10'd100, 10'd50, 2'd1, 1'b0, 1'b0);
        drive(10'd219, 10'd169, 1'b1, 1'b1, 12'd3599, 4'd4,  1'b1, "2x corner");
        drive(10'd220, 10'd169, 1'b1, 1'b1, 12'd3599, 4'd0,  1'b0, "2x past edge");
        drive(10'd100, 10'd50,  1'b1, 1'b1, 12'd0,    4'd5,  1'b1, "2x origin");
        drive(10'd103, 10'd52,  1'b1, 1'b1, 12'd61,   4'd2,  1'b1, "2x texel(1,1)");

        // scale 8x: 480x480 box needs the wide product
        latch(10'd100, 10'd50, 2'd3, 1'b0, 1'b0);
        drive(10'd579, 10'd529, 1'b1, 1'b1, 12'd3599, 4'd4,  1'b1, "8x corner");
        drive(10'd580, 10'd50,  1'b1, 1'b1, 12'd3599, 4'd0,  1'b0, "8x past edge");

        // horizontal flip
        latch(10'd100, 10'd50, 2'd0, 1'b1, 1'b0);
        drive(10'd100, 10'd50,  1'b1, 1'b1, 12'd59,   4'd0,  1'b0, "flip left col");
        drive(10'd100, 10'd51,  1'b1, 1'b1, 12'd119,  4'd12, 1'b1, "flip row1");
        drive(10'd159, 10'd50,  1'b1, 1'b1, 12'd0,    4'd5,  1'b1, "flip right col");

        // sprite hanging off the bottom-right of the screen
        latch(10'd620, 10'd470, 2'd0, 1'b0, 1'b0);
        drive(10'd639, 10'd475, 1'b1, 1'b1, 12'd319,  4'd4,  1'b1, "clip x639");
        drive(10'd0,   10'd475, 1'b1, 1'b1, 12'd319,  4'd0,  1'b0, "clip no wrap");
        drive(10'd639, 10'd479, 1'b1, 1'b1, 12'd559,  4'd4,  1'b1, "clip y479");

        // reset pulse in the middle of an opaque run
        latch(10'd100, 10'd50, 2'd0, 1'b0, 1'b0);
        drive(10'd101, 10'd50,  1'b1, 1'b1, 12'd1,    4'd6,  1'b1, "pre-reset");
        drain();
        check("pre-reset pix_hit held", int'(pix_hit), 1);
        @(negedge vga_clk);
        reset = 1'b1;
        #1;
        check("mid-line rom_addr", int'(rom_addr), 0);
        check("mid-line pix_idx", int'(pix_idx), 0);
        check("mid-line pix_hit", int'(pix_hit), 0);
        repeat (2) @(negedge vga_clk);
        reset = 1'b0;
        drive(10'd101, 10'd50,  1'b1, 1'b1, 12'd0,    4'd0,  1'b0, "post-reset 0");
        drive(10'd101, 10'd50,  1'b1, 1'b1, 12'd0,    4'd0,  1'b0, "post-reset 1");
        drive(10'd101, 10'd50,  1'b1, 1'b1, 12'd0,    4'd0,  1'b0, "post-reset 2");
        drive(10'd5,   10'd5,   1'b1, 1'b1, 12'd305,  4'd6,  1'b1, "post-reset pos0");

        // blink: frame counter restarted at 0, so frames 16..31 are dark
        for (int n = 1; n <= 33; n++) begin
            logic vis;
            vis = (n < 16) || (n >= 32);
            latch(10'd100, 10'd50, 2'd0, 1'b0, 1'b1);
            drive(10'd100, 10'd50, 1'b1, 1'b1, 12'd0, vis ? 4'd5 : 4'd0, vis,
                  $sformatf("blink frame %0d", n));
        end

        // mid-frame input changes stay invisible until the next latch
        drive(10'd100, 10'd200, 1'b1, 1'b0, 12'd0, 4'd0, 1'b0, "line 200");
        pos_x = 10'd300; blink_en = 1'b0;
        drive(10'd100, 10'd50,  1'b1, 1'b1, 12'd0,    4'd5,  1'b1, "old pos held");
        @(negedge vga_clk);
        drive(10'd0,   10'd480, 1'b0, 1'b0, 12'd0,    4'd0,  1'b0, "latch new pos");
        drive(10'd100, 10'd50,  1'b1, 1'b0, 12'd0,    4'd0,  1'b0, "old pos gone");
        drive(10'd300, 10'd50,  1'b1, 1'b1, 12'd0,    4'd5,  1'b1, "new pos");

        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
